// File: rtl/sys_defs.sv
// Shared front-end/back-end definitions used across the out-of-order core.
// Holds the rename-to-dispatch packet format and the dispatch queue depth.
package sys_defs;

    // Default number of entries in the dispatch queue
    localparam int DPQ_DEPTH = 8;

    // Physical register tag and ROB index widths
    localparam int PRN_W = 6;
    localparam int ROB_W = 5;

    // Functional unit class an instruction is steered toward
    typedef enum logic [1:0] {
        FU_ALU    = 2'd0,
        FU_MULT   = 2'd1,
        FU_MEM    = 2'd2,
        FU_BRANCH = 2'd3
    } FU_TYPE;

    // One renamed instruction travelling from rename to the RS banks
    typedef struct packed {
        logic             valid;
        logic [31:0]      pc;
        logic [31:0]      inst;
        logic [PRN_W-1:0] dest_prn;
        logic [PRN_W-1:0] src1_prn;
        logic [PRN_W-1:0] src2_prn;
        logic [ROB_W-1:0] rob_idx;
        FU_TYPE           fu;
    } RN_DP_PACKET;

endpackage

// File: rtl/dp_queue_if.sv
// Bundle of the dispatch queue's data-path signals: two packet lanes in from
// rename, two packet lanes out to the RS banks, bank-full flags, stall and
// occupancy. The master side is the rename/RS environment, the slave side
// is the queue itself.
interface dp_queue_if
    import sys_defs::*;
#(
    parameter int CNT_W = $clog2(DPQ_DEPTH) + 1
);

    RN_DP_PACKET [1:0] rn_dp_packet_in;
    logic        [1:0] rs_full;
    RN_DP_PACKET [1:0] rn_dp_packet_out;
    logic              dp_stall;
    logic [CNT_W-1:0]  dpq_count;

    modport master (
        output rn_dp_packet_in,
        output rs_full,
        input  rn_dp_packet_out,
        input  dp_stall,
        input  dpq_count
    );

    modport slave (
        input  rn_dp_packet_in,
        input  rs_full,
        output rn_dp_packet_out,
        output dp_stall,
        output dpq_count
    );

endinterface

// File: rtl/dp_queue.sv
// Two-wide in-order dispatch buffer between rename and the two RS banks.
// Buffers renamed packets in a circular array, steers the two oldest stored
// entries onto whichever RS lanes are free, and stalls rename while fewer
// than two free slots remain. Nothing bypasses from input to output: an
// entry must be stored for at least one edge before it can be dispatched.
module dp_queue
    import sys_defs::*;
#(
    parameter int DEPTH = DPQ_DEPTH,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       squash,
    dp_queue_if.slave  dpq
);

    localparam int PTR_W = $clog2(DEPTH);

    RN_DP_PACKET      mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;

    logic             stall;
    logic [1:0]       n_enq;
    logic [1:0]       n_deq;
    logic [PTR_W-1:0] head_nx1;
    logic [PTR_W-1:0] tail_lane1;
    RN_DP_PACKET [1:0] pkt_out;

    // Stall depends only on the registered count, so rename never sees a
    // combinational path from the RS full flags.
    assign stall      = (count > CNT_W'(DEPTH - 2));
    assign head_nx1   = head + PTR_W'(1);
    // A valid lane 1 packs directly behind lane 0, or into the tail slot
    // itself when lane 0 is empty, so the buffer never holds a hole.
    assign tail_lane1 = tail + PTR_W'(dpq.rn_dp_packet_in[0].valid);

    // Count the lanes accepted from rename this cycle; nothing is taken while stalled
    always_comb begin
        n_enq = 2'd0;
        if (!stall) begin
            n_enq = {1'b0, dpq.rn_dp_packet_in[0].valid}
                  + {1'b0, dpq.rn_dp_packet_in[1].valid};
        end
    end

    // Steer the oldest stored entries onto the lowest-index free RS lanes
    always_comb begin
        pkt_out = '0;
        n_deq   = 2'd0;
        if (count != '0) begin
            if (!dpq.rs_full[0]) begin
                pkt_out[0]       = mem[head];
                pkt_out[0].valid = 1'b1;
                n_deq            = 2'd1;
                if (!dpq.rs_full[1] && (count >= CNT_W'(2))) begin
                    pkt_out[1]       = mem[head_nx1];
                    pkt_out[1].valid = 1'b1;
                    n_deq            = 2'd2;
                end
            end else if (!dpq.rs_full[1]) begin
                pkt_out[1]       = mem[head];
                pkt_out[1].valid = 1'b1;
                n_deq            = 2'd1;
            end
        end
    end

    // Write accepted packets into the storage array; payload needs no reset
    always_ff @(posedge clock) begin
        if (reset && !squash && !stall) begin
            if (dpq.rn_dp_packet_in[0].valid) begin
                mem[tail] <= dpq.rn_dp_packet_in[0];
            end
            if (dpq.rn_dp_packet_in[1].valid) begin
                mem[tail_lane1] <= dpq.rn_dp_packet_in[1];
            end
        end
    end

    // Advance pointers and occupancy; squash discards this cycle's push and pop
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (squash) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PTR_W'(n_deq);
            tail  <= tail + PTR_W'(n_enq);
            count <= count + CNT_W'(n_enq) - CNT_W'(n_deq);
        end
    end

    assign dpq.rn_dp_packet_out = pkt_out;
    assign dpq.dp_stall         = stall;
    assign dpq.dpq_count        = count;

endmodule

// File: tb/tb_dp_queue.sv
// Directed bench for dp_queue: a queue-based reference model predicts the
// outputs every cycle, and literal expectations pin the key scenarios.
module tb_dp_queue;
    import sys_defs::*;

    localparam int DEPTH = DPQ_DEPTH;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic clock = 1'b0;
    logic reset;
    logic squash;

    dp_queue_if #(.CNT_W(CNT_W)) dpq_bus ();

    dp_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clock  (clock),
        .reset  (reset),
        .squash (squash),
        .dpq    (dpq_bus)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    RN_DP_PACKET model_q[$];
    RN_DP_PACKET seen0;
    RN_DP_PACKET seen1;
    RN_DP_PACKET z;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic RN_DP_PACKET mk(input int id);
        RN_DP_PACKET p;
        p          = '0;
        p.valid    = 1'b1;
        p.pc       = 32'h1000 + 32'(id) * 4;
        p.inst     = 32'hA000_0000 | 32'(id);
        p.dest_prn = PRN_W'(id);
        p.src1_prn = PRN_W'(id + 1);
        p.src2_prn = PRN_W'(id + 2);
        p.rob_idx  = ROB_W'(id);
        p.fu       = FU_TYPE'(2'(id % 4));
        return p;
    endfunction

    // Reference prediction: oldest k stored entries go, in age order, to the
    // free lanes in ascending index order.
    task automatic compare(input logic [1:0] full, output int k);
        RN_DP_PACKET exp_out[2];
        int lanes[$];
        exp_out[0] = '0;
        exp_out[1] = '0;
        for (int i = 0; i < 2; i++) if (!full[i]) lanes.push_back(i);
        k = (model_q.size() < lanes.size()) ? model_q.size() : lanes.size();
        for (int j = 0; j < k; j++) exp_out[lanes[j]] = model_q[j];
        chk("out_lane0", dpq_bus.rn_dp_packet_out[0], exp_out[0]);
        chk("out_lane1", dpq_bus.rn_dp_packet_out[1], exp_out[1]);
        chk("dp_stall", dpq_bus.dp_stall, (DEPTH - model_q.size()) < 2);
        chk("dpq_count", dpq_bus.dpq_count, model_q.size());
        seen0 = dpq_bus.rn_dp_packet_out[0];
        seen1 = dpq_bus.rn_dp_packet_out[1];
    endtask

    // One clock cycle: drive, check settled outputs, advance the model at the edge
    task automatic cyc(input RN_DP_PACKET p0, input RN_DP_PACKET p1,
                       input logic [1:0] full, input logic sq);
        int  k;
        bit  stl;
        dpq_bus.rn_dp_packet_in[0] = p0;
        dpq_bus.rn_dp_packet_in[1] = p1;
        dpq_bus.rs_full            = full;
        squash                     = sq;
        #1;
        compare(full, k);
        stl = (DEPTH - model_q.size()) < 2;
        @(posedge clock);
        if (sq) begin
            model_q.delete();
        end else begin
            repeat (k) void'(model_q.pop_front());
            if (!stl) begin
                if (p0.valid) model_q.push_back(p0);
                if (p1.valid) model_q.push_back(p1);
            end
        end
        @(negedge clock);
    endtask

    initial begin
        int id;
        int guard;
        logic [1:0] pats [4];
        RN_DP_PACKET w0;
        RN_DP_PACKET w1;
        bit stl;

        z = '0;
        pats[0] = 2'b00; pats[1] = 2'b01; pats[2] = 2'b10; pats[3] = 2'b11;
        reset  = 1'b0;
        squash = 1'b0;
        dpq_bus.rn_dp_packet_in = '0;
        dpq_bus.rs_full = 2'b00;

        // Reset state
        repeat (2) @(negedge clock);
        #1;
        chk("reset_count", dpq_bus.dpq_count, 0);
        chk("reset_stall", dpq_bus.dp_stall, 1'b0);
        chk("reset_lane0", dpq_bus.rn_dp_packet_out[0], 0);
        chk("reset_lane1", dpq_bus.rn_dp_packet_out[1], 0);
        reset = 1'b1;
        @(negedge clock);

        // 1. Asynchronous reset in the middle of operation
        cyc(mk(1), mk(2), 2'b11, 1'b0);
        cyc(mk(3), mk(4), 2'b11, 1'b0);
        cyc(mk(5), z, 2'b11, 1'b0);
        chk("t1_count5", dpq_bus.dpq_count, 5);
        dpq_bus.rn_dp_packet_in = '0;
        dpq_bus.rs_full = 2'b00;
        #2;
        reset = 1'b0;
        #1;
        chk("t1_async_count", dpq_bus.dpq_count, 0);
        chk("t1_async_stall", dpq_bus.dp_stall, 1'b0);
        chk("t1_async_lane0", dpq_bus.rn_dp_packet_out[0], 0);
        chk("t1_async_lane1", dpq_bus.rn_dp_packet_out[1], 0);
        model_q.delete();
        @(negedge clock);
        reset = 1'b1;
        #1;

        // 2. Backpressure fills the buffer and the stall blocks further input
        cyc(mk(10), mk(11), 2'b11, 1'b0);
        chk("t2_count2", dpq_bus.dpq_count, 2);
        cyc(mk(12), mk(13), 2'b11, 1'b0);
        chk("t2_count4", dpq_bus.dpq_count, 4);
        cyc(mk(14), mk(15), 2'b11, 1'b0);
        chk("t2_count6", dpq_bus.dpq_count, 6);
        chk("t2_stall_at6", dpq_bus.dp_stall, 1'b0);
        cyc(mk(16), mk(17), 2'b11, 1'b0);
        chk("t2_count8", dpq_bus.dpq_count, 8);
        chk("t2_stall_at8", dpq_bus.dp_stall, 1'b1);
        cyc(mk(18), mk(19), 2'b11, 1'b0);
        chk("t2_ignored_count", dpq_bus.dpq_count, 8);
        repeat (4) cyc(z, z, 2'b00, 1'b0);
        chk("t2_last_lane1", seen1, mk(17));
        chk("t2_drained", dpq_bus.dpq_count, 0);

        // 3. Steering around a full bank 0
        cyc(mk(20), mk(21), 2'b11, 1'b0);
        cyc(mk(22), z, 2'b11, 1'b0);
        chk("t3_count3", dpq_bus.dpq_count, 3);
        cyc(z, z, 2'b01, 1'b0);
        chk("t3_lane1_A", seen1, mk(20));
        chk("t3_lane0_inv", seen0, 0);
        chk("t3_count2", dpq_bus.dpq_count, 2);
        cyc(z, z, 2'b00, 1'b0);
        chk("t3_lane0_B", seen0, mk(21));
        chk("t3_lane1_C", seen1, mk(22));

        // 5. Sparse input: only lane 1 valid
        cyc(z, mk(30), 2'b11, 1'b0);
        chk("t5_count1", dpq_bus.dpq_count, 1);
        cyc(z, z, 2'b00, 1'b0);
        chk("t5_lane0_X", seen0, mk(30));
        chk("t5_lane1_inv", seen1, 0);

        // 4. Stream 20 packets past the pointer wrap with varying bank availability
        id = 0;
        guard = 0;
        while (id < 20 && guard < 200) begin
            w0  = mk(100 + id);
            w1  = (id + 1 < 20) ? mk(101 + id) : z;
            stl = (DEPTH - model_q.size()) < 2;
            cyc(w0, w1, pats[guard % 4], 1'b0);
            if (!stl) id += (id + 1 < 20) ? 2 : 1;
            guard++;
        end
        chk("t4_all_sent", id, 20);
        guard = 0;
        while (model_q.size() != 0 && guard < 20) begin
            cyc(z, z, 2'b00, 1'b0);
            guard++;
        end
        chk("t4_drained", dpq_bus.dpq_count, 0);

        // 6. Squash with simultaneous push and pop
        cyc(mk(40), mk(41), 2'b11, 1'b0);
        cyc(mk(42), mk(43), 2'b11, 1'b0);
        chk("t6_count4", dpq_bus.dpq_count, 4);
        cyc(mk(44), mk(45), 2'b00, 1'b1);
        chk("t6_count0", dpq_bus.dpq_count, 0);
        repeat (3) cyc(z, z, 2'b00, 1'b0);
        chk("t6_lane0_inv", seen0, 0);
        chk("t6_lane1_inv", seen1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
